// File: rtl/uart_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_pkg
// Brief    : Shared response codes, command-byte layout and FSM state encoding
//            for the UART-to-block-RAM bridge.
// Revision : 1.0 - initial release
// ============================================================================
package uart_mem_pkg;

    // Response bytes returned over the UART
    localparam logic [7:0] c_ACK = 8'hAA;
    localparam logic [7:0] c_ERR = 8'hEE;

    // Command byte layout: [7] write/read, [6:4] reserved (must be 0), [3:0] address
    localparam int c_CMD_WR_BIT   = 7;
    localparam int c_CMD_RSV_HI   = 6;
    localparam int c_CMD_RSV_LO   = 4;
    localparam int c_CMD_ADDR_HI  = 3;
    localparam int c_CMD_ADDR_LO  = 0;

    // Bridge FSM state encoding
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_DATA  = 3'd1,
        WRITE     = 3'd2,
        READ_WAIT = 3'd3,
        SEND      = 3'd4
    } state_t;

    // A command is well-formed only when its reserved field is all zeros
    function automatic logic cmdRsvClear(input logic [7:0] cmd);
        return (cmd[c_CMD_RSV_HI:c_CMD_RSV_LO] == 3'b000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : cycle_timer
// Brief    : One-shot cycle counter. A start pulse (re)arms it; expire pulses
//            for one cycle once COUNT cycles have elapsed since the start.
// Revision : 1.0 - initial release
// ============================================================================
module cycle_timer #(
    parameter int COUNT = 27000000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic expire
);

    localparam int c_CNT_W = $clog2(COUNT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(COUNT - 1);

    logic [c_CNT_W-1:0] r_count;
    logic               r_run;

    // Expire is asserted during the COUNT-th cycle after the start edge
    assign expire = r_run && (r_count == c_LAST);

    // Count while armed; start always wins so a re-arm restarts cleanly
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_run   <= 1'b0;
        end else if (start) begin
            r_count <= '0;
            r_run   <= 1'b1;
        end else if (r_run) begin
            if (expire) begin
                r_count <= '0;
                r_run   <= 1'b0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_bridge
// Brief    : Decodes single-byte UART commands into block-RAM reads/writes and
//            returns one response byte (ACK, ERR or read data) per command.
// Revision : 1.0 - initial release
// ============================================================================
module uart_mem_bridge
    import uart_mem_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 8,
    parameter int READ_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 27000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              mem_ce,
    output logic              mem_oce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              err_overrun,
    output logic              err_timeout
);

    localparam int c_LAT_W = $clog2(READ_LATENCY + 2);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(READ_LATENCY);

    state_t             r_state;
    logic [c_LAT_W-1:0] r_latCnt;
    logic               w_timerStart;
    logic               w_timerExpire;
    logic               w_busy;

    // The RAM is always clocked and its output register always enabled
    assign mem_ce  = 1'b1;
    assign mem_oce = 1'b1;

    // Arm the data-byte timeout on the same edge that enters GET_DATA
    assign w_timerStart = (r_state == IDLE) && rx_valid && cmdRsvClear(rx_data)
                          && rx_data[c_CMD_WR_BIT];

    // States in which an incoming byte cannot be consumed
    assign w_busy = (r_state == WRITE) || (r_state == READ_WAIT) || (r_state == SEND);

    cycle_timer #(
        .COUNT  (TIMEOUT_CYCLES)
    ) u_dataTimer (
        .clk    (clk),
        .reset  (reset),
        .start  (w_timerStart),
        .expire (w_timerExpire)
    );

    // Command FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_latCnt    <= '0;
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
            mem_wre     <= 1'b0;
            mem_ad      <= '0;
            mem_din     <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            mem_wre  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (rx_valid) begin
                        if (!cmdRsvClear(rx_data)) begin
                            tx_data <= c_ERR;
                            r_state <= SEND;
                        end else begin
                            mem_ad <= ADDR_W'(rx_data[c_CMD_ADDR_HI:c_CMD_ADDR_LO]);
                            if (rx_data[c_CMD_WR_BIT]) begin
                                r_state <= GET_DATA;
                            end else begin
                                r_latCnt <= '0;
                                r_state  <= READ_WAIT;
                            end
                        end
                    end
                end

                GET_DATA: begin
                    // A byte landing on the expiry cycle still counts as on time
                    if (rx_valid) begin
                        mem_din <= DATA_W'(rx_data);
                        mem_wre <= 1'b1;
                        r_state <= WRITE;
                    end else if (w_timerExpire) begin
                        err_timeout <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                WRITE: begin
                    tx_data <= c_ACK;
                    r_state <= SEND;
                end

                READ_WAIT: begin
                    // mem_ad settled on entry; data is valid after READ_LATENCY cycles
                    if (r_latCnt == c_LAT_LAST) begin
                        tx_data <= 8'(mem_dout);
                        r_state <= SEND;
                    end else begin
                        r_latCnt <= r_latCnt + 1'b1;
                    end
                end

                SEND: begin
                    if (tx_ready) begin
                        tx_start <= 1'b1;
                        r_state  <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase

            if (rx_valid && w_busy) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mem_bridge
// Brief    : Directed self-checking bench for uart_mem_bridge with a
//            two-stage pipelined RAM model behind the memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mem_bridge;

    localparam int c_ADDR_W  = 4;
    localparam int c_DATA_W  = 8;
    localparam int c_RD_LAT  = 2;
    localparam int c_TIMEOUT = 100;

    logic                clk = 1'b0;
    logic                reset;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                tx_ready;
    logic [7:0]          tx_data;
    logic                tx_start;
    logic                mem_ce;
    logic                mem_oce;
    logic                mem_wre;
    logic [c_ADDR_W-1:0] mem_ad;
    logic [c_DATA_W-1:0] mem_din;
    logic [c_DATA_W-1:0] mem_dout;
    logic                err_overrun;
    logic                err_timeout;

    int compCnt  = 0;
    int errCnt   = 0;
    int cyc      = 0;
    int txCount  = 0;
    int wreCount = 0;
    int lastTxCyc  = 0;
    int lastTxData = 0;
    int lastWrAd   = 0;
    int lastWrDin  = 0;
    int byteCyc    = 0;

    uart_mem_bridge #(
        .ADDR_W         (c_ADDR_W),
        .DATA_W         (c_DATA_W),
        .READ_LATENCY   (c_RD_LAT),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .mem_ce      (mem_ce),
        .mem_oce     (mem_oce),
        .mem_wre     (mem_wre),
        .mem_ad      (mem_ad),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Pipelined RAM: address registered on one edge, output register on the next.
    // Initial contents are 0x10 + address.
    logic [7:0] ram [16];
    logic [7:0] ramStage;
    logic       ramLoaded = 1'b0;
    always @(posedge clk) begin
        if (!ramLoaded) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'(8'h10 + i);
            ramLoaded <= 1'b1;
        end else if (mem_ce) begin
            if (mem_wre) ram[mem_ad] <= mem_din;
            else         ramStage   <= ram[mem_ad];
        end
        if (mem_ce && mem_oce) mem_dout <= ramStage;
    end

    // Output monitor, sampled just after each rising edge
    always begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (tx_start) begin
            txCount    = txCount + 1;
            lastTxCyc  = cyc;
            lastTxData = int'(tx_data);
        end
        if (mem_wre) begin
            wreCount  = wreCount + 1;
            lastWrAd  = int'(mem_ad);
            lastWrDin = int'(mem_din);
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compCnt = compCnt + 1;
        if (act !== exp) begin
            errCnt = errCnt + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present one byte for one cycle; byteCyc is the monitor cycle of its sampling edge
    task automatic sendByte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        byteCyc  = cyc;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for a new tx_start beyond startCnt
    task automatic waitTx(input string tag, input int startCnt, input int budget);
        int k;
        k = 0;
        while (txCount == startCnt && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkValue(tag, 32'(txCount != startCnt), 32'd1);
    endtask

    int t0;
    int w0;
    int cmdCyc;

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        idle(3);

        // Reset state
        checkValue("rst_tx_start",    32'(tx_start),    32'd0);
        checkValue("rst_mem_wre",     32'(mem_wre),     32'd0);
        checkValue("rst_tx_data",     32'(tx_data),     32'h00);
        checkValue("rst_mem_ad",      32'(mem_ad),      32'd0);
        checkValue("rst_mem_din",     32'(mem_din),     32'h00);
        checkValue("rst_err_overrun", 32'(err_overrun), 32'd0);
        checkValue("rst_err_timeout", 32'(err_timeout), 32'd0);
        checkValue("rst_mem_ce",      32'(mem_ce),      32'd1);
        checkValue("rst_mem_oce",     32'(mem_oce),     32'd1);
        reset = 1'b0;
        idle(2);

        // Test 1: write 0x5A to address 3 -> ACK two cycles after the data byte
        t0 = txCount; w0 = wreCount;
        sendByte(8'h83);
        sendByte(8'h5A);
        cmdCyc = byteCyc;
        waitTx("wr_tx_seen", t0, 20);
        idle(3);
        checkValue("wr_pulses",   32'(wreCount - w0),      32'd1);
        checkValue("wr_addr",     32'(lastWrAd),           32'd3);
        checkValue("wr_din",      32'(lastWrDin),          32'h5A);
        checkValue("wr_tx_data",  32'(lastTxData),         32'hAA);
        checkValue("wr_tx_count", 32'(txCount - t0),       32'd1);
        checkValue("wr_latency",  32'(lastTxCyc - cmdCyc), 32'd2);

        // Test 2: read address 3 -> 0x5A, READ_LATENCY+2 = 4 cycles after the command
        t0 = txCount; w0 = wreCount;
        sendByte(8'h03);
        cmdCyc = byteCyc;
        waitTx("rd_tx_seen", t0, 20);
        idle(3);
        checkValue("rd_data",     32'(lastTxData),         32'h5A);
        checkValue("rd_latency",  32'(lastTxCyc - cmdCyc), 32'd4);
        checkValue("rd_tx_count", 32'(txCount - t0),       32'd1);
        checkValue("rd_no_write", 32'(wreCount - w0),      32'd0);

        // Test 3: reserved bits set -> ERR, next cycle after the command
        t0 = txCount; w0 = wreCount;
        sendByte(8'h93);
        cmdCyc = byteCyc;
        waitTx("bad_tx_seen", t0, 20);
        idle(3);
        checkValue("bad_data",     32'(lastTxData),         32'hEE);
        checkValue("bad_latency",  32'(lastTxCyc - cmdCyc), 32'd1);
        checkValue("bad_no_write", 32'(wreCount - w0),      32'd0);

        // Test 4: write command without a data byte -> timeout after 100 cycles
        t0 = txCount; w0 = wreCount;
        sendByte(8'h81);
        idle(94);
        checkValue("to_not_early", 32'(err_timeout), 32'd0);
        idle(10);
        checkValue("to_flag",      32'(err_timeout),   32'd1);
        checkValue("to_no_write",  32'(wreCount - w0), 32'd0);
        checkValue("to_no_tx",     32'(txCount - t0),  32'd0);
        // Back in IDLE: a fresh read of address 1 answers normally
        sendByte(8'h01);
        cmdCyc = byteCyc;
        waitTx("to_rd_tx_seen", t0, 20);
        idle(2);
        checkValue("to_rd_data",    32'(lastTxData),         32'h11);
        checkValue("to_rd_latency", 32'(lastTxCyc - cmdCyc), 32'd4);

        // Test 5: response held off by tx_ready=0 while a stray byte arrives
        tx_ready = 1'b0;
        t0 = txCount;
        sendByte(8'h03);
        idle(10);
        sendByte(8'h22);
        idle(38);
        checkValue("ovr_held",     32'(txCount - t0), 32'd0);
        checkValue("ovr_flag",     32'(err_overrun),  32'd1);
        tx_ready = 1'b1;
        waitTx("ovr_tx_seen", t0, 10);
        idle(6);
        checkValue("ovr_tx_count", 32'(txCount - t0), 32'd1);
        checkValue("ovr_data",     32'(lastTxData),   32'h5A);

        // Test 6: reset during GET_DATA aborts the write and clears sticky flags
        t0 = txCount; w0 = wreCount;
        sendByte(8'h84);
        idle(1);
        reset = 1'b1;
        idle(2);
        checkValue("ab_err_overrun", 32'(err_overrun), 32'd0);
        checkValue("ab_err_timeout", 32'(err_timeout), 32'd0);
        checkValue("ab_mem_din",     32'(mem_din),     32'h00);
        reset = 1'b0;
        idle(2);
        checkValue("ab_no_tx",       32'(txCount - t0),  32'd0);
        // 0x44 is taken as a command, not as write data; bits6:4 = 100 make it ERR
        sendByte(8'h44);
        waitTx("ab_cmd_tx_seen", t0, 20);
        idle(2);
        checkValue("ab_cmd_data",    32'(lastTxData),    32'hEE);
        // Address 4 still holds its initial contents
        t0 = txCount;
        sendByte(8'h04);
        waitTx("ab_rd_tx_seen", t0, 20);
        idle(2);
        checkValue("ab_rd_data",     32'(lastTxData),    32'h14);
        checkValue("ab_no_write",    32'(wreCount - w0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, errCnt);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
